// File: rtl/riscv_regfile_sb.sv
// Parametrised RISC-V integer register file with load-data extension on writeback,
// write-to-read bypass and a per-register load scoreboard for decode stalls.
module riscv_regfile_sb #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int AW     = 5,
    parameter int NRD    = 2,
    parameter int BYPASS = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NRD*AW-1:0]     rs_addr,
    output logic [NRD*XLEN-1:0]   rs_data,
    output logic [NRD-1:0]        rs_busy,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [XLEN-1:0]       wr_data,
    input  logic                  wr_load,
    input  logic [2:0]            wr_func3,
    input  logic                  busy_set,
    input  logic [AW-1:0]         busy_addr,
    output logic                  err_func3
);

    // LD and LWU only exist on RV64; everything outside the table is illegal.
    function automatic logic func3_legal(input logic [2:0] f3);
        logic legal;
        case (f3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
            3'b011, 3'b110:                         legal = (XLEN == 64);
            default:                                legal = 1'b0;
        endcase
        return legal;
    endfunction

    // Extension is done in a 64-bit frame and truncated, so LW on RV32 is the full word.
    function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] raw,
                                                 input logic [2:0]      f3);
        logic [63:0] raw64;
        logic [63:0] ext64;
        raw64 = 64'(raw);
        case (f3)
            3'b000:  ext64 = {{56{raw64[7]}},  raw64[7:0]};
            3'b001:  ext64 = {{48{raw64[15]}}, raw64[15:0]};
            3'b010:  ext64 = {{32{raw64[31]}}, raw64[31:0]};
            3'b011:  ext64 = raw64;
            3'b100:  ext64 = {56'h0, raw64[7:0]};
            3'b101:  ext64 = {48'h0, raw64[15:0]};
            3'b110:  ext64 = {32'h0, raw64[31:0]};
            default: ext64 = raw64;
        endcase
        return ext64[XLEN-1:0];
    endfunction

    logic [XLEN-1:0]            regs_r [NREGS];
    logic [NREGS-1:0]           busy_r;
    logic [NREGS-1:0]           busy_nxt_s;
    logic [XLEN-1:0]            ext_s;
    logic                       f3_ok_s;
    logic                       wr_legal_s;
    logic                       err_s;
    logic [NRD-1:0][XLEN-1:0]   rd_data_s;
    logic [NRD-1:0]             rd_busy_s;

    // Writeback decode: extended value, legality and illegal-funct3 detection.
    always_comb begin
        f3_ok_s    = func3_legal(wr_func3);
        ext_s      = wr_data;
        wr_legal_s = 1'b0;
        err_s      = 1'b0;
        if (wr_load) begin
            ext_s = load_ext(wr_data, wr_func3);
        end else begin
            ext_s = wr_data;
        end
        if (wr_en) begin
            wr_legal_s = (wr_addr != {AW{1'b0}}) && (!wr_load || f3_ok_s);
            err_s      = wr_load && !f3_ok_s;
        end else begin
            wr_legal_s = 1'b0;
            err_s      = 1'b0;
        end
    end

    // Scoreboard next state: clear on writeback, then set on issue so a new load wins.
    always_comb begin
        busy_nxt_s = busy_r;
        if (wr_legal_s) begin
            busy_nxt_s[wr_addr] = 1'b0;
        end else begin
            busy_nxt_s = busy_r;
        end
        if (busy_set && (busy_addr != {AW{1'b0}})) begin
            busy_nxt_s[busy_addr] = 1'b1;
        end else begin
            busy_nxt_s[0] = 1'b0;
        end
        busy_nxt_s[0] = 1'b0;
    end

    // Read ports: x0 is zero, optional forwarding of the write in flight.
    always_comb begin
        rd_data_s = '0;
        rd_busy_s = '0;
        for (int i = 0; i < NRD; i++) begin
            logic [AW-1:0] a;
            a = rs_addr[i*AW +: AW];
            if (a == {AW{1'b0}}) begin
                rd_data_s[i] = {XLEN{1'b0}};
            end else if ((BYPASS != 0) && wr_legal_s && (a == wr_addr)) begin
                rd_data_s[i] = ext_s;
            end else begin
                rd_data_s[i] = regs_r[a];
            end
            rd_busy_s[i] = busy_nxt_s[a];
        end
    end

    // State and registered outputs; reset overrides any write or issue this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_r[r] <= {XLEN{1'b0}};
            end
            busy_r    <= {NREGS{1'b0}};
            rs_data   <= {(NRD*XLEN){1'b0}};
            rs_busy   <= {NRD{1'b0}};
            err_func3 <= 1'b0;
        end else begin
            if (wr_legal_s) begin
                regs_r[wr_addr] <= ext_s;
            end
            busy_r <= busy_nxt_s;
            for (int i = 0; i < NRD; i++) begin
                rs_data[i*XLEN +: XLEN] <= rd_data_s[i];
            end
            rs_busy   <= rd_busy_s;
            err_func3 <= err_s;
        end
    end

endmodule

// File: doc/riscv_regfile_sb.md
Name: riscv_regfile_sb

Overview:
Parametrised integer register file for the RISC-V core, replacing the fixed 32x32 two-read-port file.
- Configurable XLEN, register count and number of read ports.
- Integrated load-data extension on writeback.
- Write-to-read bypass.
- Per-register load scoreboard (busy bits) so decode can stall on pending loads.
- Sits between decode (read side) and writeback (write side).

Parameters:
XLEN, 32, data width; legal values 32 or 64.
NREGS, 32, number of architectural registers; x0 hard-wired to zero.
AW, 5, register address width; must equal clog2(NREGS).
NRD, 2, number of read ports.
BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return the pre-write value.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous active-high reset.
rs_addr  input  NRD*AW  read addresses; port i occupies bits [i*AW +: AW].
rs_data  output  NRD*XLEN  registered read data; port i occupies bits [i*XLEN +: XLEN].
rs_busy  output  NRD  registered busy flag per read port.
wr_en  input  1  writeback valid.
wr_addr  input  AW  writeback destination.
wr_data  input  XLEN  writeback data (raw memory data when wr_load=1).
wr_load  input  1  1 = apply load extension selected by wr_func3.
wr_func3  input  3  load funct3.
busy_set  input  1  load issued this cycle; mark busy_addr pending.
busy_addr  input  AW  destination of the issued load.
err_func3  output  1  one-cycle pulse on illegal load funct3.

Behaviour:
- Reset: when rst=1 at a clk edge, all registers, all busy bits, rs_data, rs_busy and err_func3 are cleared to 0. rst has priority over every other input; a write or busy_set in the same cycle is discarded.
- Reads:
  - Latency is 1 cycle. rs_data[i] is updated on every clock edge from rs_addr[i], including cycles with wr_en=1.
  - rs_addr = 0 always returns 0.
- Write:
  - On a clk edge with wr_en=1 and wr_addr != 0, the register takes the extended value ext.
  - If wr_load=0, ext = wr_data.
  - If wr_load=1, ext is selected by wr_func3:
    - 000 LB: sign-extend bits [7:0].
    - 001 LH: sign-extend bits [15:0].
    - 010 LW: XLEN=32 takes the full word; XLEN=64 sign-extends bits [31:0].
    - 100 LBU: zero-extend bits [7:0].
    - 101 LHU: zero-extend bits [15:0].
    - 011 LD and 110 LWU: legal only when XLEN=64 (LD takes the full value, LWU zero-extends bits [31:0]).
  - Any other wr_func3 with wr_load=1 is illegal:
    - No register write; busy bit unchanged.
    - err_func3=1 for exactly the next cycle.
  - Writes to x0 are ignored.
- Bypass:
  - Applies when BYPASS=1, a legal write occurs, and rs_addr[i] == wr_addr != 0.
  - In that case rs_data[i] takes ext in the same edge.
  - When BYPASS=0, rs_data[i] takes the old register value.
- Scoreboard (busy[NREGS], busy[0] constantly 0):
  - A legal write to wr_addr clears busy[wr_addr].
  - busy_set with busy_addr != 0 sets busy[busy_addr].
  - Set and clear to the same address in the same cycle: set wins (the new load is pending).
  - rs_busy[i] is registered and equals the busy bit of rs_addr[i] after this cycle's updates, i.e. consistent with the bypassed rs_data.
- Multiple read ports on the same address each return identical data and busy values.
- All state is flops; no read-during-reset hazard. The first rs_data after rst deasserts reflects the cleared file.

Test Plan:
1. Reset: write x5=0x12345678, assert rst for 1 cycle, read x5 -> rs_data=0, rs_busy=0.
2. Bypass:
   - BYPASS=1: wr_en, wr_addr=7, wr_data=0xCAFEBABE with rs_addr0=7 in the same cycle -> rs_data0=0xCAFEBABE next cycle.
   - BYPASS=0: same stimulus -> old value 0.
3. Load extension, XLEN=32, wr_data=0x0000F08F:
   - func3 000 -> 0xFFFFFF8F.
   - 001 -> 0xFFFFF08F.
   - 100 -> 0x0000008F.
   - 101 -> 0x0000F08F.
4. Scoreboard:
   - busy_set addr=9 -> rs_busy for x9 = 1.
   - Later write x9 -> rs_busy=0.
   - Simultaneous busy_set x9 and write x9 -> rs_busy stays 1, data updated.
5. Illegal funct3: XLEN=32, wr_load=1, func3=011, wr_addr=4 -> x4 unchanged, busy[4] unchanged, err_func3 high for exactly 1 cycle.
6. x0: write 0xFFFFFFFF to x0 with busy_set addr=0 -> reads of x0 return 0 and rs_busy=0 on all NRD ports.
